// File: rtl/estacao_reserva_if.sv
// Reservation-station bundle: issue port, CDB snoop port and the
// functional-unit dispatch handshake (fu_iIn offer / fu_disponivel idle).
//   master : the reservation station side (drives issue_ready, illegal_op,
//            occupancy and the fu_* offer)
//   slave  : the environment side (issue logic, CDB and the functional unit)
interface estacao_reserva_if #(
  parameter int TAGW  = 3,
  parameter int DATAW = 16
);
  // issue
  logic             issue_valid;
  logic [DATAW-1:0] issue_instruction;
  logic [TAGW-1:0]  issue_tag;
  logic [DATAW-1:0] issue_Vj;
  logic [DATAW-1:0] issue_Vk;
  logic [TAGW-1:0]  issue_Qj;
  logic [TAGW-1:0]  issue_Qk;
  logic             issue_ready;
  logic             illegal_op;
  // common data bus
  logic             cdb_valid;
  logic [TAGW-1:0]  cdb_tag;
  logic [DATAW-1:0] cdb_value;
  // functional unit dispatch
  logic             fu_disponivel;
  logic             fu_iIn;
  logic [DATAW-1:0] fu_instruction;
  logic [TAGW-1:0]  fu_tag;
  logic [DATAW-1:0] fu_R2;
  logic [DATAW-1:0] fu_R1;
  // status
  logic [3:0]       occupancy;

  modport master (
    input  issue_valid, issue_instruction, issue_tag, issue_Vj, issue_Vk,
           issue_Qj, issue_Qk, cdb_valid, cdb_tag, cdb_value, fu_disponivel,
    output issue_ready, illegal_op, fu_iIn, fu_instruction, fu_tag,
           fu_R2, fu_R1, occupancy
  );

  modport slave (
    output issue_valid, issue_instruction, issue_tag, issue_Vj, issue_Vk,
           issue_Qj, issue_Qk, cdb_valid, cdb_tag, cdb_value, fu_disponivel,
    input  issue_ready, illegal_op, fu_iIn, fu_instruction, fu_tag,
           fu_R2, fu_R1, occupancy
  );
endinterface

// File: rtl/estacao_reserva.sv
// Reservation station for the Tomasulo core.
// Holds DEPTH issued instructions, snoops the CDB for missing operands and
// offers the lowest-index ready entry to one functional unit.
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous active-high reset
//   bus        estacao_reserva_if.master (issue, CDB, FU dispatch, occupancy)

// One reservation-station entry. Tag 0 means "operand present".
module estacao_reserva_entrada #(
  parameter int TAGW  = 3,
  parameter int DATAW = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr,
  input  logic             free,
  input  logic [DATAW-1:0] in_op,
  input  logic [TAGW-1:0]  in_tag,
  input  logic [DATAW-1:0] in_vj,
  input  logic [DATAW-1:0] in_vk,
  input  logic [TAGW-1:0]  in_qj,
  input  logic [TAGW-1:0]  in_qk,
  input  logic             cdb_valid,
  input  logic [TAGW-1:0]  cdb_tag,
  input  logic [DATAW-1:0] cdb_value,
  output logic             busy,
  output logic             ready,
  output logic [DATAW-1:0] op,
  output logic [TAGW-1:0]  tag,
  output logic [DATAW-1:0] vj,
  output logic [DATAW-1:0] vk
);
  logic [TAGW-1:0] qj, qk;
  logic            cdb_live;

  assign cdb_live = cdb_valid && (cdb_tag != '0);
  assign ready    = busy && (qj == '0) && (qk == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy <= 1'b0;
      op   <= '0;
      tag  <= '0;
      vj   <= '0;
      vk   <= '0;
      qj   <= '0;
      qk   <= '0;
    end else if (wr) begin
      busy <= 1'b1;
      op   <= in_op;
      tag  <= in_tag;
      // same-cycle broadcast of the producer is captured here, else lost
      if (cdb_live && in_qj == cdb_tag) begin
        vj <= cdb_value;
        qj <= '0;
      end else begin
        vj <= in_vj;
        qj <= in_qj;
      end
      if (cdb_live && in_qk == cdb_tag) begin
        vk <= cdb_value;
        qk <= '0;
      end else begin
        vk <= in_vk;
        qk <= in_qk;
      end
    end else if (free) begin
      busy <= 1'b0;
    end else if (busy && cdb_live) begin
      if (qj == cdb_tag) begin
        vj <= cdb_value;
        qj <= '0;
      end
      if (qk == cdb_tag) begin
        vk <= cdb_value;
        qk <= '0;
      end
    end
  end
endmodule

module estacao_reserva #(
  parameter int DEPTH = 3,
  parameter int TAGW  = 3,
  parameter int DATAW = 16
) (
  input  logic               clock,
  input  logic               reset,
  estacao_reserva_if.master  bus
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {IDLE, OFFER} st_t;

  st_t                          state;
  logic [DEPTH-1:0]             busy, ready, wr, free;
  logic [DEPTH-1:0][DATAW-1:0]  e_op, e_vj, e_vk;
  logic [DEPTH-1:0][TAGW-1:0]   e_tag;
  logic                         has_free, has_ready, op_legal, accept;
  logic [IW-1:0]                free_idx, rdy_idx, sel_q;
  logic [3:0]                   occ;

  logic             iin_q, ill_q;
  logic [DATAW-1:0] instr_q, r2_q, r1_q;
  logic [TAGW-1:0]  tag_q;

  // lowest-index free and ready entries (descending scan keeps the lowest)
  always_comb begin
    has_free  = 1'b0;
    free_idx  = '0;
    has_ready = 1'b0;
    rdy_idx   = '0;
    occ       = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        has_free = 1'b1;
        free_idx = IW'(i);
      end
      if (ready[i]) begin
        has_ready = 1'b1;
        rdy_idx   = IW'(i);
      end
      occ = occ + {3'b000, busy[i]};
    end
  end

  always_comb begin
    case (bus.issue_instruction[3:0])
      4'h0, 4'h1, 4'h4, 4'h5: op_legal = 1'b1;
      default:                op_legal = 1'b0;
    endcase
  end

  assign accept = bus.issue_valid && has_free && op_legal;

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    assign wr[i]   = accept && (free_idx == IW'(i));
    // the unit samples the offer at the edge where it reports idle
    assign free[i] = (state == OFFER) && bus.fu_disponivel && (sel_q == IW'(i));

    estacao_reserva_entrada #(.TAGW(TAGW), .DATAW(DATAW)) u_ent (
      .clock     (clock),
      .reset     (reset),
      .wr        (wr[i]),
      .free      (free[i]),
      .in_op     (bus.issue_instruction),
      .in_tag    (bus.issue_tag),
      .in_vj     (bus.issue_Vj),
      .in_vk     (bus.issue_Vk),
      .in_qj     (bus.issue_Qj),
      .in_qk     (bus.issue_Qk),
      .cdb_valid (bus.cdb_valid),
      .cdb_tag   (bus.cdb_tag),
      .cdb_value (bus.cdb_value),
      .busy      (busy[i]),
      .ready     (ready[i]),
      .op        (e_op[i]),
      .tag       (e_tag[i]),
      .vj        (e_vj[i]),
      .vk        (e_vk[i])
    );
  end

  // Dispatch FSM. Readiness comes from registered entry state, so an entry
  // issued or woken at an edge is only offered from the following edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      iin_q   <= 1'b0;
      instr_q <= DATAW'(16'h000F);
      tag_q   <= '0;
      r2_q    <= '0;
      r1_q    <= '0;
      sel_q   <= '0;
      ill_q   <= 1'b0;
    end else begin
      // rejected only when the issue would otherwise have been taken
      ill_q <= bus.issue_valid && has_free && !op_legal;
      case (state)
        IDLE: begin
          if (bus.fu_disponivel && has_ready) begin
            state   <= OFFER;
            iin_q   <= 1'b1;
            sel_q   <= rdy_idx;
            instr_q <= e_op[rdy_idx];
            tag_q   <= e_tag[rdy_idx];
            r2_q    <= e_vj[rdy_idx];
            r1_q    <= e_vk[rdy_idx];
          end
        end
        OFFER: begin
          if (bus.fu_disponivel) begin
            state <= IDLE;
            iin_q <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          iin_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.issue_ready    = has_free;
  assign bus.illegal_op     = ill_q;
  assign bus.fu_iIn         = iin_q;
  assign bus.fu_instruction = instr_q;
  assign bus.fu_tag         = tag_q;
  assign bus.fu_R2          = r2_q;
  assign bus.fu_R1          = r1_q;
  assign bus.occupancy      = occ;
endmodule

// File: tb/tb_estacao_reserva.sv
module tb_estacao_reserva;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clock = ~clock;

  estacao_reserva_if #(.TAGW(3), .DATAW(16)) bus ();

  estacao_reserva #(.DEPTH(3), .TAGW(3), .DATAW(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [15:0] instr, input logic [2:0] tag,
                       input logic [15:0] vj, input logic [15:0] vk,
                       input logic [2:0] qj, input logic [2:0] qk,
                       input logic cv, input logic [2:0] ct, input logic [15:0] cval,
                       input logic disp);
    bus.issue_valid       = iv;
    bus.issue_instruction = instr;
    bus.issue_tag         = tag;
    bus.issue_Vj          = vj;
    bus.issue_Vk          = vk;
    bus.issue_Qj          = qj;
    bus.issue_Qk          = qk;
    bus.cdb_valid         = cv;
    bus.cdb_tag           = ct;
    bus.cdb_value         = cval;
    bus.fu_disponivel     = disp;
  endtask

  task automatic idle(input logic disp);
    drive(0, 16'h0, 0, 0, 0, 0, 0, 0, 0, 0, disp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic iv; logic [15:0] instr; logic [2:0] tag; logic [15:0] vj, vk;
    logic [2:0] qj, qk; logic cv; logic [2:0] ct; logic [15:0] cval; logic disp;
    logic e_iin; logic [15:0] e_instr; logic [2:0] e_tag; logic [15:0] e_r2, e_r1;
    logic [3:0] e_occ; logic e_rdy; logic e_ill;
  } vec_t;

  function automatic vec_t mk(logic iv, logic [15:0] instr, logic [2:0] tag,
                              logic [15:0] vj, logic [15:0] vk, logic [2:0] qj, logic [2:0] qk,
                              logic cv, logic [2:0] ct, logic [15:0] cval, logic disp,
                              logic e_iin, logic [15:0] e_instr, logic [2:0] e_tag,
                              logic [15:0] e_r2, logic [15:0] e_r1,
                              logic [3:0] e_occ, logic e_rdy, logic e_ill);
    vec_t v;
    v.iv = iv; v.instr = instr; v.tag = tag; v.vj = vj; v.vk = vk; v.qj = qj; v.qk = qk;
    v.cv = cv; v.ct = ct; v.cval = cval; v.disp = disp;
    v.e_iin = e_iin; v.e_instr = e_instr; v.e_tag = e_tag; v.e_r2 = e_r2; v.e_r1 = e_r1;
    v.e_occ = e_occ; v.e_rdy = e_rdy; v.e_ill = e_ill;
    return v;
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    bit busy; logic [15:0] op; logic [2:0] tag;
    logic [15:0] vj, vk; logic [2:0] qj, qk;
  } ent_t;

  ent_t        m [3];
  bit          m_off;
  int          m_idx;
  logic [15:0] m_op, m_r2, m_r1;
  logic [2:0]  m_tag;
  bit          m_ill;

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) m[i] = '{0, 0, 0, 0, 0, 0, 0};
    m_off = 0; m_idx = 0; m_ill = 0;
  endfunction

  function automatic int model_occ();
    int n = 0;
    for (int i = 0; i < 3; i++) n += m[i].busy ? 1 : 0;
    return n;
  endfunction

  // Next state of the station given the inputs currently on the bus.
  function automatic void model_edge();
    ent_t old [3];
    int   nfree = -1;
    bit   legal, live;
    old = m;
    for (int i = 2; i >= 0; i--) if (!old[i].busy) nfree = i;
    live  = bus.cdb_valid && bus.cdb_tag != 0;
    legal = bus.issue_instruction[3:0] inside {4'h0, 4'h1, 4'h4, 4'h5};
    if (m_off) begin
      if (bus.fu_disponivel) begin
        m[m_idx].busy = 0;
        m_off = 0;
      end
    end else if (bus.fu_disponivel) begin
      for (int i = 0; i < 3 && !m_off; i++)
        if (old[i].busy && old[i].qj == 0 && old[i].qk == 0) begin
          m_off = 1; m_idx = i;
          m_op = old[i].op; m_tag = old[i].tag; m_r2 = old[i].vj; m_r1 = old[i].vk;
        end
    end
    if (live)
      for (int i = 0; i < 3; i++)
        if (old[i].busy) begin
          if (old[i].qj == bus.cdb_tag) begin m[i].vj = bus.cdb_value; m[i].qj = 0; end
          if (old[i].qk == bus.cdb_tag) begin m[i].vk = bus.cdb_value; m[i].qk = 0; end
        end
    m_ill = 0;
    if (bus.issue_valid && nfree >= 0) begin
      if (legal) begin
        m[nfree].busy = 1;
        m[nfree].op   = bus.issue_instruction;
        m[nfree].tag  = bus.issue_tag;
        m[nfree].vj   = bus.issue_Vj;
        m[nfree].vk   = bus.issue_Vk;
        m[nfree].qj   = bus.issue_Qj;
        m[nfree].qk   = bus.issue_Qk;
        if (live && bus.issue_Qj == bus.cdb_tag) begin m[nfree].vj = bus.cdb_value; m[nfree].qj = 0; end
        if (live && bus.issue_Qk == bus.cdb_tag) begin m[nfree].vk = bus.cdb_value; m[nfree].qk = 0; end
      end else begin
        m_ill = 1;
      end
    end
  endfunction

  // ---------------- test ----------------
  initial begin
    vec_t tbl [18];
    int   n;
    logic [3:0] op4;

    tbl[0]  = mk(1, 16'h0000, 1, 5, 3, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 1, 1, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,         1, 1, 16'h0000, 1, 5, 3, 1, 1, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,         1, 0, 0, 0, 0, 0, 0, 1, 0);
    tbl[3]  = mk(1, 16'h0001, 2, 0, 7, 4, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 1, 1, 0);
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,         1, 0, 0, 0, 0, 0, 1, 1, 0);
    tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 4, 20,        1, 0, 0, 0, 0, 0, 1, 1, 0);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,         1, 1, 16'h0001, 2, 20, 7, 1, 1, 0);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,         1, 0, 0, 0, 0, 0, 0, 1, 0);
    tbl[8]  = mk(1, 16'h0004, 5, 2, 0, 0, 3, 1, 3, 9,  1, 0, 0, 0, 0, 0, 1, 1, 0);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,         1, 1, 16'h0004, 5, 2, 9, 1, 1, 0);
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,         0, 1, 16'h0004, 5, 2, 9, 1, 1, 0);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,         1, 0, 0, 0, 0, 0, 0, 1, 0);
    tbl[12] = mk(1, 16'h0003, 1, 1, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 1, 1);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,         1, 0, 0, 0, 0, 0, 0, 1, 0);
    tbl[14] = mk(1, 16'h0005, 6, 11, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 99,        0, 0, 0, 0, 0, 0, 1, 1, 0);
    tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,         1, 1, 16'h0005, 6, 11, 4, 1, 1, 0);
    tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,         1, 0, 0, 0, 0, 0, 0, 1, 0);

    // reset state
    idle(1);
    #12;
    chk("rst_iIn",   bus.fu_iIn, 0);
    chk("rst_instr", bus.fu_instruction, 16'h000F);
    chk("rst_tag",   bus.fu_tag, 0);
    chk("rst_R2",    bus.fu_R2, 0);
    chk("rst_R1",    bus.fu_R1, 0);
    chk("rst_ready", bus.issue_ready, 1);
    chk("rst_ill",   bus.illegal_op, 0);
    chk("rst_occ",   bus.occupancy, 0);
    @(negedge clock);
    reset = 1'b0;

    // directed table
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].iv, tbl[i].instr, tbl[i].tag, tbl[i].vj, tbl[i].vk, tbl[i].qj, tbl[i].qk,
            tbl[i].cv, tbl[i].ct, tbl[i].cval, tbl[i].disp);
      tick();
      chk($sformatf("vec%0d_iIn", i),   bus.fu_iIn, tbl[i].e_iin);
      chk($sformatf("vec%0d_occ", i),   bus.occupancy, tbl[i].e_occ);
      chk($sformatf("vec%0d_ready", i), bus.issue_ready, tbl[i].e_rdy);
      chk($sformatf("vec%0d_ill", i),   bus.illegal_op, tbl[i].e_ill);
      if (tbl[i].e_iin) begin
        chk($sformatf("vec%0d_instr", i), bus.fu_instruction, tbl[i].e_instr);
        chk($sformatf("vec%0d_tag", i),   bus.fu_tag, tbl[i].e_tag);
        chk($sformatf("vec%0d_R2", i),    bus.fu_R2, tbl[i].e_r2);
        chk($sformatf("vec%0d_R1", i),    bus.fu_R1, tbl[i].e_r1);
      end
    end

    // fill all entries waiting on tag 6, then wake them together
    for (int k = 0; k < 3; k++) begin
      drive(1, 16'h0000, 3'(k + 1), 0, 16'(10 + k), 6, 0, 0, 0, 0, 0);
      tick();
      chk($sformatf("fill%0d_occ", k), bus.occupancy, 4'(k + 1));
    end
    chk("full_ready", bus.issue_ready, 0);
    drive(1, 16'h0000, 7, 1, 1, 0, 0, 0, 0, 0, 0);
    tick();
    chk("full_ignored_occ", bus.occupancy, 3);
    chk("full_ignored_ill", bus.illegal_op, 0);
    chk("full_ignored_ready", bus.issue_ready, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 6, 50, 0);
    tick();
    chk("wake_no_offer", bus.fu_iIn, 0);
    for (int k = 0; k < 3; k++) begin
      idle(1);
      n = 0;
      do begin tick(); n++; end while (!bus.fu_iIn && n < 10);
      chk($sformatf("order%0d_offer_seen", k), bus.fu_iIn, 1);
      chk($sformatf("order%0d_tag", k), bus.fu_tag, 3'(k + 1));
      chk($sformatf("order%0d_R2", k),  bus.fu_R2, 50);
      chk($sformatf("order%0d_R1", k),  bus.fu_R1, 16'(10 + k));
      idle(0);
      tick();
      chk($sformatf("order%0d_hold", k), bus.fu_iIn, 1);
      idle(1);
      tick();
      chk($sformatf("order%0d_done", k), bus.fu_iIn, 0);
      chk($sformatf("order%0d_occ", k),  bus.occupancy, 4'(2 - k));
      chk($sformatf("order%0d_ready", k), bus.issue_ready, 1);
      idle(0);
      tick();
      chk($sformatf("order%0d_wait", k), bus.fu_iIn, 0);
    end

    // asynchronous reset in the middle of an offer
    drive(1, 16'h0000, 1, 8, 1, 0, 0, 0, 0, 0, 1);
    tick();
    idle(1);
    tick();
    chk("pre_reset_offer", bus.fu_iIn, 1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_iIn",   bus.fu_iIn, 0);
    chk("async_rst_occ",   bus.occupancy, 0);
    chk("async_rst_ready", bus.issue_ready, 1);
    chk("async_rst_instr", bus.fu_instruction, 16'h000F);
    @(negedge clock);
    reset = 1'b0;
    drive(1, 16'h0000, 3, 1, 2, 0, 0, 0, 0, 0, 1);
    tick();
    idle(1);
    tick();
    chk("post_rst_iIn", bus.fu_iIn, 1);
    chk("post_rst_tag", bus.fu_tag, 3);
    chk("post_rst_R2",  bus.fu_R2, 1);
    chk("post_rst_R1",  bus.fu_R1, 2);

    // randomized run against the reference model
    reset = 1'b1;
    model_reset();
    idle(0);
    @(negedge clock);
    reset = 1'b0;
    for (int c = 0; c < 400; c++) begin
      case ($urandom_range(0, 5))
        0: op4 = 4'h0;
        1: op4 = 4'h1;
        2: op4 = 4'h4;
        3: op4 = 4'h5;
        4: op4 = 4'h3;
        default: op4 = 4'hA;
      endcase
      drive($urandom_range(0, 1) == 1,
            {12'($urandom), op4},
            3'($urandom_range(1, 7)),
            16'($urandom), 16'($urandom),
            ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 3)) : 3'd0,
            ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 3)) : 3'd0,
            $urandom_range(0, 2) == 0,
            3'($urandom_range(0, 3)),
            16'($urandom),
            $urandom_range(0, 9) < 7);
      model_edge();
      tick();
      chk($sformatf("rnd%0d_ready", c), bus.issue_ready, (model_occ() < 3) ? 1 : 0);
      chk($sformatf("rnd%0d_occ", c),   bus.occupancy, 4'(model_occ()));
      chk($sformatf("rnd%0d_ill", c),   bus.illegal_op, m_ill);
      chk($sformatf("rnd%0d_iIn", c),   bus.fu_iIn, m_off);
      if (m_off) begin
        chk($sformatf("rnd%0d_instr", c), bus.fu_instruction, m_op);
        chk($sformatf("rnd%0d_tag", c),   bus.fu_tag, m_tag);
        chk($sformatf("rnd%0d_R2", c),    bus.fu_R2, m_r2);
        chk($sformatf("rnd%0d_R1", c),    bus.fu_R1, m_r1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/estacao_reserva.md
Name: estacao_reserva

Overview:
- Reservation station for the Tomasulo core. It is the initiator side of the functional-unit dispatch interface.
- It accepts issued instructions with operand values or producer tags, and snoops the common data bus (CDB) for missing operands.
- It offers ready instructions to one functional unit (add/sub/mul/div) using that unit's iIn / disponivel handshake.

Parameters:
- DEPTH, 3, number of entries (2..8).
- TAGW, 3, tag width. Tag 0 is reserved and means "no dependency / value present".
- DATAW, 16, operand and instruction width.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- issue_valid  in  1  issue request this cycle.
- issue_instruction  in  16  instruction word; opcode in [3:0].
- issue_tag  in  TAGW  destination tag of the instruction (nonzero).
- issue_Vj, issue_Vk  in  16  operand values.
- issue_Qj, issue_Qk  in  TAGW  producer tags; 0 = corresponding V is valid.
- issue_ready  out  1  at least one entry is free.
- illegal_op  out  1  one-cycle pulse when an issue is rejected for an unsupported opcode.
- cdb_valid  in  1  CDB broadcast valid.
- cdb_tag  in  TAGW  broadcasting tag.
- cdb_value  in  16  broadcast result.
- fu_disponivel  in  1  functional unit idle.
- fu_iIn  out  1  dispatch offer.
- fu_instruction  out  16  instruction offered.
- fu_tag  out  TAGW  tag offered.
- fu_R2  out  16  first source (Vj); the unit computes R2 op R1.
- fu_R1  out  16  second source (Vk).
- occupancy  out  4  number of busy entries.

Behaviour:
- Reset (asynchronous, any state, including mid-offer):
  - All entries cleared; FSM returns to IDLE.
  - fu_iIn=0, fu_instruction=16'h000F, fu_tag=0, fu_R1=fu_R2=0.
  - issue_ready=1, illegal_op=0, occupancy=0.
- Entry fields: busy, op[15:0], tag, Vj, Vk, Qj, Qk.
- An entry is ready when busy and Qj==0 and Qk==0.
- Issue:
  - Accepted at a posedge when issue_valid=1, issue_ready=1 and the opcode is one of 0000, 0001, 0100, 0101.
  - The accepted instruction is written to the lowest-index free entry.
  - An unsupported opcode sets illegal_op=1 for one cycle and writes no entry.
  - issue_valid while issue_ready=0 is ignored; no state change and no pulse.
- CDB snoop:
  - Applies at every posedge with cdb_valid=1 and cdb_tag!=0.
  - Every busy entry with Qj==cdb_tag loads Vj=cdb_value and sets Qj=0. Same rule for Qk/Vk.
  - cdb_tag=0 is ignored.
- Issue/CDB bypass: if an accepted issue has issue_Qj (or issue_Qk) equal to cdb_tag on a valid broadcast in the same cycle, the entry is written with cdb_value and Q=0. The operand is never lost.
- Dispatch FSM:
  - IDLE: if fu_disponivel=1 and any ready entry exists, select the lowest-index ready entry. Register its fields onto the fu_* outputs, set fu_iIn=1, latch the index, go to OFFER. No offer in the cycle that entry is issued or woken.
  - OFFER: fu_iIn held at 1 with stable outputs. At a posedge with fu_disponivel=1 the unit has sampled the offer: free the entry, fu_iIn=0, return to IDLE. If fu_disponivel=0, hold in OFFER.
  - Minimum spacing between dispatches is 2 cycles. The unit's own latency (1 for add/sub, 2 for mul/div) gates further offers through fu_disponivel.
- Issue into a freed slot:
  - The slot freed at a posedge is free for issue from the next cycle.
  - issue_ready is combinational from registered busy bits.
- occupancy is updated at the same edge as issue and free. Simultaneous issue and free leaves occupancy unchanged.
- DEPTH entries busy → issue_ready=0. It rises the cycle after a dispatch completes.

Test Plan:
- Issue ADD (instr 16'h0000, tag 1, Vj=5, Vk=3, Q=0) with fu_disponivel=1 → next cycle fu_iIn=1, fu_R2=5, fu_R1=3, fu_tag=1; freed after the accepting edge; occupancy returns 0.
- Issue SUB (tag 2, Qj=4, Vk=7), then CDB tag 4 value 20 → no offer before the broadcast; next cycle offer with fu_R2=20, fu_R1=7.
- Issue with issue_Qk=3 in the same cycle as CDB tag 3 value 9 → entry captures Vk=9; offered without waiting for another broadcast.
- Fill all 3 entries with Qj=6, issue a 4th → issue_ready=0, 4th ignored. CDB tag 6 → entries dispatched in index order 0,1,2, each waiting on fu_disponivel.
- Issue opcode 0011 → illegal_op pulses 1 cycle; occupancy stays 0.
- Assert reset while in OFFER → fu_iIn=0 immediately (asynchronous), occupancy=0, issue_ready=1; the next ADD issue dispatches normally.
